// File: rtl/crossbar_pkg.sv
// Shared constants for the 2x2 crossbar scheduler.
//   DATA_W_DFLT     default payload width
//   FIFO_DEPTH_DFLT default per-input queue depth (power of two, >= 2)
//   DEST_OUT1/2     destination encodings carried with each packet
package crossbar_pkg;
  localparam int   DATA_W_DFLT     = 4;
  localparam int   FIFO_DEPTH_DFLT = 2;
  localparam logic DEST_OUT1       = 1'b0;
  localparam logic DEST_OUT2       = 1'b1;
endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO used as one input queue of the crossbar scheduler.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, din     write request / data (ignored while full, even if popping)
//   pop           read request (ignored while empty)
//   full, empty   derived from the registered occupancy count only
//   head          oldest entry, valid whenever !empty
module fifo_sync #(
  parameter int W     = 5,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are AW bits wide, so incrementing wraps modulo DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/crossbar_2x2_scheduler.sv
// Two-input queued scheduler driving a 2x2 crossbar.
// Each input port has a FIFO of {dest, data}. Every cycle the two heads are
// examined; non-conflicting heads are both served, conflicting heads are
// resolved by a toggling priority bit. Results are registered.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   inN_valid/data/dest/ready      input port N handshake (N = 1, 2)
//   xb_in1, xb_in2                 payloads presented to the crossbar
//   xb_control                     0 = straight, 1 = crossed
//   out1_valid, out2_valid         crossbar output K carries a packet
module crossbar_2x2_scheduler
  import crossbar_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DFLT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_dest,
  output logic              in1_ready,
  input  logic              in2_valid,
  input  logic [DATA_W-1:0] in2_data,
  input  logic              in2_dest,
  output logic              in2_ready,
  output logic [DATA_W-1:0] xb_in1,
  output logic [DATA_W-1:0] xb_in2,
  output logic              xb_control,
  output logic              out1_valid,
  output logic              out2_valid
);
  localparam int EW = DATA_W + 1;

  logic          full1, full2, empty1, empty2;
  logic [EW-1:0] head1, head2;
  logic          serve1, serve2;
  logic          h1, h2, d1, d2;

  logic              prio_q, prio_d;
  logic [DATA_W-1:0] xb_in1_q, xb_in1_d, xb_in2_q, xb_in2_d;
  logic              xb_control_q, xb_control_d;
  logic              out1_valid_q, out1_valid_d, out2_valid_q, out2_valid_d;

  fifo_sync #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst),
    .push(in1_valid), .din({in1_dest, in1_data}), .pop(serve1),
    .full(full1), .empty(empty1), .head(head1)
  );

  fifo_sync #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo2 (
    .clk(clk), .rst(rst),
    .push(in2_valid), .din({in2_dest, in2_data}), .pop(serve2),
    .full(full2), .empty(empty2), .head(head2)
  );

  assign in1_ready = !full1;
  assign in2_ready = !full2;

  assign h1 = !empty1;
  assign h2 = !empty2;
  assign d1 = head1[DATA_W];
  assign d2 = head2[DATA_W];

  always_comb begin
    serve1 = 1'b0;
    serve2 = 1'b0;
    prio_d = prio_q;
    if (h1 && h2) begin
      if (d1 != d2) begin
        serve1 = 1'b1;
        serve2 = 1'b1;
      end else begin
        // Same destination: alternate winners so neither port starves.
        if (!prio_q) serve1 = 1'b1;
        else         serve2 = 1'b1;
        prio_d = ~prio_q;
      end
    end else begin
      serve1 = h1;
      serve2 = h2;
    end

    xb_in1_d = serve1 ? head1[DATA_W-1:0] : '0;
    xb_in2_d = serve2 ? head2[DATA_W-1:0] : '0;
    // Port 1 reaches its dest straight when d1=0; port 2 alone needs the
    // opposite setting to reach its dest. When both are served d2 = ~d1.
    if (serve1)      xb_control_d = d1;
    else if (serve2) xb_control_d = ~d2;
    else             xb_control_d = 1'b0;
    out1_valid_d = (serve1 && d1 == DEST_OUT1) || (serve2 && d2 == DEST_OUT1);
    out2_valid_d = (serve1 && d1 == DEST_OUT2) || (serve2 && d2 == DEST_OUT2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q       <= 1'b0;
      xb_in1_q     <= '0;
      xb_in2_q     <= '0;
      xb_control_q <= 1'b0;
      out1_valid_q <= 1'b0;
      out2_valid_q <= 1'b0;
    end else begin
      prio_q       <= prio_d;
      xb_in1_q     <= xb_in1_d;
      xb_in2_q     <= xb_in2_d;
      xb_control_q <= xb_control_d;
      out1_valid_q <= out1_valid_d;
      out2_valid_q <= out2_valid_d;
    end
  end

  assign xb_in1     = xb_in1_q;
  assign xb_in2     = xb_in2_q;
  assign xb_control = xb_control_q;
  assign out1_valid = out1_valid_q;
  assign out2_valid = out2_valid_q;
endmodule

// File: tb/tb_crossbar_2x2_scheduler.sv
// Directed bench for crossbar_2x2_scheduler (DATA_W=4, FIFO_DEPTH=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Observed vector layout: {xb_in1, xb_in2, xb_control, out1_valid,
// out2_valid, in1_ready, in2_ready}.
module tb_crossbar_2x2_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in1_valid = 1'b0, in2_valid = 1'b0;
  logic [3:0] in1_data = '0, in2_data = '0;
  logic       in1_dest = 1'b0, in2_dest = 1'b0;
  logic       in1_ready, in2_ready;
  logic [3:0] xb_in1, xb_in2;
  logic       xb_control, out1_valid, out2_valid;

  int checks = 0;
  int failures = 0;

  logic [12:0] exp3 [1:10];
  logic [3:0]  d1_tab [1:6];
  logic [3:0]  d2_tab [1:6];

  crossbar_2x2_scheduler #(.DATA_W(4), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_dest(in1_dest), .in1_ready(in1_ready),
    .in2_valid(in2_valid), .in2_data(in2_data), .in2_dest(in2_dest), .in2_ready(in2_ready),
    .xb_in1(xb_in1), .xb_in2(xb_in2), .xb_control(xb_control),
    .out1_valid(out1_valid), .out2_valid(out2_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] ev(logic [3:0] a, logic [3:0] b, logic c,
                                     logic o1, logic o2, logic r1, logic r2);
    return {a, b, c, o1, o2, r1, r2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [12:0] expv);
    logic [12:0] obs;
    obs = {xb_in1, xb_in2, xb_control, out1_valid, out2_valid, in1_ready, in2_ready};
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v1, input logic ds1, input logic [3:0] dt1,
                       input logic v2, input logic ds2, input logic [3:0] dt2);
    in1_valid = v1; in1_dest = ds1; in1_data = dt1;
    in2_valid = v2; in2_dest = ds2; in2_data = dt2;
  endtask

  initial begin
    d1_tab[1] = 4'd1; d1_tab[2] = 4'd2; d1_tab[3] = 4'd3;
    d1_tab[4] = 4'd4; d1_tab[5] = 4'd4; d1_tab[6] = 4'd5;
    d2_tab[1] = 4'd9;  d2_tab[2] = 4'd10; d2_tab[3] = 4'd11;
    d2_tab[4] = 4'd11; d2_tab[5] = 4'd12; d2_tab[6] = 4'd12;
    exp3[1]  = ev(4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    exp3[2]  = ev(4'd1, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    exp3[3]  = ev(4'd0, 4'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    exp3[4]  = ev(4'd2, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    exp3[5]  = ev(4'd0, 4'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    exp3[6]  = ev(4'd3, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    exp3[7]  = ev(4'd0, 4'd11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    exp3[8]  = ev(4'd4, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    exp3[9]  = ev(4'd0, 4'd12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    exp3[10] = ev(4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset: cleared outputs, both queues ready.
    #1;
    chk("rst_held", ev(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_released", ev(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

    // Different destinations on both ports: crossed, both outputs valid.
    drive(1'b1, 1'b1, 4'hA, 1'b1, 1'b0, 4'h5);
    step();
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    chk("t1_accept_edge", ev(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    step();
    chk("t1_crossed", ev(4'hA, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    step();
    chk("t1_idle", ev(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

    // Port 2 alone to out2: straight, only out2 valid.
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h7);
    step();
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    step();
    chk("t2_in2_only", ev(4'd0, 4'h7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    step();
    chk("t2_idle", ev(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

    // Persistent conflict on out1: alternation from port 1, queues fill,
    // full queue refuses a push even while popping, then drain.
    for (int e = 1; e <= 10; e++) begin
      if (e <= 6) drive(1'b1, 1'b0, d1_tab[e], 1'b1, 1'b0, d2_tab[e]);
      else        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
      step();
      chk($sformatf("t3_conflict_e%0d", e), exp3[e]);
    end

    // Priority is now 1: port 2 wins the first conflict, port 1 fills.
    drive(1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 4'hC);
    step();
    chk("t4_fill_a", ev(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    drive(1'b1, 1'b0, 4'h2, 1'b1, 1'b0, 4'hD);
    step();
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    chk("t4_fill_b", ev(4'd0, 4'hC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    rst = 1'b1;
    #1;
    chk("t4_async_clear", ev(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    step();
    rst = 1'b0;
    chk("t4_rst_edge", ev(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t4_no_emit_%0d", i), ev(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    end

    // Reset restored priority 0: port 1 wins, then port 2 alone to out2.
    drive(1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 4'h6);
    step();
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    chk("t5_accept", ev(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    step();
    chk("t5_port1_wins", ev(4'h3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
    step();
    chk("t5_port2_alone", ev(4'd0, 4'h6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    step();
    chk("t5_idle", ev(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/crossbar_2x2_scheduler.md
CROSSBAR_2X2_SCHEDULER -- requirements
Module: crossbar_2x2_scheduler

Interface
REQ-001 Parameters SHALL be: DATA_W, 4, payload width; FIFO_DEPTH, 2, entries per input queue (power of two, >=2).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Ports SHALL be, in this order:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in1_valid  input  1  port-1 packet offered
- in1_data  input  DATA_W  port-1 payload
- in1_dest  input  1  port-1 destination (0=out1, 1=out2)
- in1_ready  output  1  port-1 queue can accept
- in2_valid  input  1  port-2 packet offered
- in2_data  input  DATA_W  port-2 payload
- in2_dest  input  1  port-2 destination (0=out1, 1=out2)
- in2_ready  output  1  port-2 queue can accept
- xb_in1  output  DATA_W  to crossbar in1
- xb_in2  output  DATA_W  to crossbar in2
- xb_control  output  1  crossbar select (0=straight in1->out1/in2->out2, 1=crossed in1->out2/in2->out1)
- out1_valid  output  1  crossbar out1 carries a packet this cycle
- out2_valid  output  1  crossbar out2 carries a packet this cycle

Function
REQ-004 Packet accepted on a port at a rising edge when valid && ready; {dest,data} pushed into that port's FIFO.
REQ-005 inN_ready SHALL equal !fullN, combinational from registered count only; no push when full, even if the same cycle pops.
REQ-006 Scheduling SHALL use the two FIFO heads (h1,d1),(h2,d2) each cycle, combinationally; results registered into all xb_*/outN_valid outputs at the next edge.
REQ-007 Both heads present, d1!=d2: both popped, xb_control<=d1, both outN_valid<=1.
REQ-008 Both heads present, d1==d2 (conflict): winner = port1 if prio==0 else port2; only winner popped; prio toggles.
REQ-009 Exactly one head present: that head popped; prio unchanged.
REQ-010 Served port1 SHALL set xb_control<=d1; served port2 alone SHALL set xb_control<=~d2.
REQ-011 Unserved port's xb_inN SHALL be driven 0; served port's xb_inN SHALL carry its payload.
REQ-012 outK_valid<=1 iff a served packet's dest selects out K.
REQ-013 No head present: xb_in1=xb_in2=0, xb_control=0, out1_valid=out2_valid=0.
REQ-014 Latency: packet accepted at edge k into an empty FIFO with no conflict SHALL appear on outputs after edge k+1.
REQ-015 Throughput: one packet per port per cycle sustained when destinations differ; FIFO order preserved per port.
REQ-016 Downstream always accepts (no backpressure); no packet dropped or duplicated.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH; simultaneous push and pop on a non-full FIFO leaves count unchanged.

Reset
REQ-018 rst asserted SHALL immediately clear FIFOs (count 0), prio=0, all outputs 0, inN_ready=1 after rst deasserts.
REQ-019 rst mid-traffic SHALL discard all queued packets; none emitted after release.

Structure
REQ-020 Package crossbar_pkg SHALL hold DATA_W default, FIFO_DEPTH default, DEST_OUT1=0, DEST_OUT2=1.
REQ-021 One sub-module fifo_sync (DATA_W+1 wide, FIFO_DEPTH deep, push/pop/full/empty/head) SHALL be instantiated twice; scheduler logic lives in top.

Verification
REQ-022 Reset: rst=1 then release -> all outputs 0, in1_ready=in2_ready=1.
REQ-023 in1 {dest=1,data=4'hA}, in2 {dest=0,data=4'h5} same edge -> next cycle xb_control=1, xb_in1=A, xb_in2=5, out1_valid=out2_valid=1.
REQ-024 Both ports dest=0 every cycle, data 1,2,3.. -> out1 alternates port1/port2 (port1 first), out2_valid=0, readies drop when FIFOs fill.
REQ-025 Only in2 {dest=1,data=4'h7} -> xb_control=0, xb_in2=7, xb_in1=0, out2_valid=1 only.
REQ-026 Fill port1 FIFO (2 pkts, other port blocking via conflict), assert rst one cycle -> no queued packet emitted, ready=1.
